bsg_cache_dma_mem_model: RTL and testbench

//  Nonsynth backing-memory model on the bsg_cache DMA interface.
//  - Accepts DMA packets (block read/fill, block write/evict) and streams block_size_in_words_p words.
//  - Adds programmable read latency ahead of each fill.
//  - Sits directly downstream of bsg_cache in cache testbenches.

---
 rtl/bsg_cache_dma_mem_model_if.sv | 27 ++
 rtl/bsg_cache_dma_mem_model.sv | 124 ++++++++++++
 tb/tb_bsg_cache_dma_mem_model.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/bsg_cache_dma_mem_model_if.sv
// DMA link between bsg_cache and its backing memory model.
// The signal names are taken from the memory model's side of the link.
interface bsg_cache_dma_mem_model_if #(
  parameter int unsigned addr_width_p = 32,
  parameter int unsigned data_width_p = 32
);
  logic [addr_width_p:0]   dma_pkt_i;
  logic                    dma_pkt_v_i;
  logic                    dma_pkt_yumi_o;
  logic [data_width_p-1:0] dma_data_o;
  logic                    dma_data_v_o;
  logic                    dma_data_ready_i;
  logic [data_width_p-1:0] dma_data_i;
  logic                    dma_data_v_i;
  logic                    dma_data_yumi_o;
  logic                    busy_o;

  modport slave (
    input  dma_pkt_i, dma_pkt_v_i, dma_data_ready_i, dma_data_i, dma_data_v_i,
    output dma_pkt_yumi_o, dma_data_o, dma_data_v_o, dma_data_yumi_o, busy_o
  );

  modport master (
    output dma_pkt_i, dma_pkt_v_i, dma_data_ready_i, dma_data_i, dma_data_v_i,
    input  dma_pkt_yumi_o, dma_data_o, dma_data_v_o, dma_data_yumi_o, busy_o
  );
endinterface

// File: rtl/bsg_cache_dma_mem_model.sv
// Backing-memory model for the bsg_cache DMA port.
// It streams block fills after a programmable latency and absorbs block evicts.
module bsg_cache_dma_mem_model #(
  parameter int unsigned addr_width_p          = 32,
  parameter int unsigned data_width_p          = 32,
  parameter int unsigned block_size_in_words_p = 4,
  parameter int unsigned els_p                 = 128,
  parameter int unsigned read_latency_p        = 2
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  bsg_cache_dma_mem_model_if.slave      dma_if
);

  localparam int unsigned lg_bytes_lp = $clog2(data_width_p / 8);
  localparam int unsigned idx_w_lp    = $clog2(els_p);
  localparam int unsigned beat_w_lp   = $clog2(block_size_in_words_p) + 1;
  localparam int unsigned lat_w_lp    = (read_latency_p > 0) ? $clog2(read_latency_p + 1) : 1;

  typedef enum logic [1:0] {IDLE, RD_LAT, RD_SEND, WR_RECV} state_e;

  state_e                  state_q, state_d;
  logic [beat_w_lp-1:0]    beat_q, beat_d;
  logic [lat_w_lp-1:0]     lat_q, lat_d;
  logic [idx_w_lp-1:0]     base_q, base_d;
  logic [data_width_p-1:0] mem_q [els_p];

  logic                    mem_we;
  logic [idx_w_lp-1:0]     pkt_idx;
  logic [idx_w_lp-1:0]     beat_idx;
  logic                    last_beat;

  // The byte address becomes a word index that wraps at els_p and is aligned to the block.
  assign pkt_idx   = idx_w_lp'(dma_if.dma_pkt_i[addr_width_p-1:0] >> lg_bytes_lp)
                   & ~idx_w_lp'(block_size_in_words_p - 1);
  assign beat_idx  = base_q + idx_w_lp'(beat_q);
  assign last_beat = (beat_q == beat_w_lp'(block_size_in_words_p - 1));

  // Control state. Reset also reloads the memory with its index pattern, so a partial evict is discarded.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      beat_q  <= '0;
      lat_q   <= '0;
      base_q  <= '0;
      for (int i = 0; i < int'(els_p); i++) begin
        mem_q[i] <= data_width_p'(i);
      end
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      lat_q   <= lat_d;
      base_q  <= base_d;
      if (mem_we) begin
        mem_q[beat_idx] <= dma_if.dma_data_i;
      end
    end
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_d                = state_q;
    beat_d                 = beat_q;
    lat_d                  = lat_q;
    base_d                 = base_q;
    mem_we                 = 1'b0;
    dma_if.dma_pkt_yumi_o  = 1'b0;
    dma_if.dma_data_o      = '0;
    dma_if.dma_data_v_o    = 1'b0;
    dma_if.dma_data_yumi_o = 1'b0;
    dma_if.busy_o          = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        // The reset gate keeps a pending packet from being consumed while reset is asserted.
        dma_if.dma_pkt_yumi_o = dma_if.dma_pkt_v_i & reset_n_i;
        if (dma_if.dma_pkt_v_i) begin
          base_d = pkt_idx;
          beat_d = '0;
          if (dma_if.dma_pkt_i[addr_width_p]) begin
            state_d = WR_RECV;
          end else if (read_latency_p == 0) begin
            state_d = RD_SEND;
          end else begin
            state_d = RD_LAT;
            lat_d   = lat_w_lp'(read_latency_p);
          end
        end
      end

      RD_LAT: begin
        lat_d = lat_q - lat_w_lp'(1);
        if (lat_q == lat_w_lp'(1)) begin
          state_d = RD_SEND;
        end
      end

      RD_SEND: begin
        dma_if.dma_data_v_o = 1'b1;
        dma_if.dma_data_o   = mem_q[beat_idx];
        if (dma_if.dma_data_ready_i) begin
          beat_d = beat_q + beat_w_lp'(1);
          if (last_beat) begin
            state_d = IDLE;
          end
        end
      end

      WR_RECV: begin
        dma_if.dma_data_yumi_o = dma_if.dma_data_v_i;
        if (dma_if.dma_data_v_i) begin
          mem_we = 1'b1;
          beat_d = beat_q + beat_w_lp'(1);
          if (last_beat) begin
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_bsg_cache_dma_mem_model.sv
// Directed bench for bsg_cache_dma_mem_model: a reference memory feeds a queue of expected fill words.
// Instance u_dut2 uses read latency 2 and instance u_dut0 uses read latency 0.
module tb_bsg_cache_dma_mem_model;
  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned BS  = 4;
  localparam int unsigned ELS = 128;

  logic clk = 1'b0;
  logic reset_n;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bsg_cache_dma_mem_model_if #(.addr_width_p(AW), .data_width_p(DW)) if2 ();
  bsg_cache_dma_mem_model_if #(.addr_width_p(AW), .data_width_p(DW)) if0 ();

  // Shared stimulus. sel steers the packet and evict valids to one instance (0: u_dut2, 1: u_dut0).
  logic          sel;
  logic [AW:0]   pkt;
  logic          pkt_v, ready, dat_v;
  logic [DW-1:0] dat;

  assign if2.dma_pkt_i        = pkt;
  assign if2.dma_pkt_v_i      = pkt_v & ~sel;
  assign if2.dma_data_ready_i = ready;
  assign if2.dma_data_i       = dat;
  assign if2.dma_data_v_i     = dat_v & ~sel;
  assign if0.dma_pkt_i        = pkt;
  assign if0.dma_pkt_v_i      = pkt_v & sel;
  assign if0.dma_data_ready_i = ready;
  assign if0.dma_data_i       = dat;
  assign if0.dma_data_v_i     = dat_v & sel;

  wire          yumi  = sel ? if0.dma_pkt_yumi_o  : if2.dma_pkt_yumi_o;
  wire          dv    = sel ? if0.dma_data_v_o    : if2.dma_data_v_o;
  wire [DW-1:0] dout  = sel ? if0.dma_data_o      : if2.dma_data_o;
  wire          dyumi = sel ? if0.dma_data_yumi_o : if2.dma_data_yumi_o;
  wire          busy  = sel ? if0.busy_o          : if2.busy_o;

  bsg_cache_dma_mem_model #(
    .addr_width_p(AW), .data_width_p(DW), .block_size_in_words_p(BS),
    .els_p(ELS), .read_latency_p(2)
  ) u_dut2 (.clk_i(clk), .reset_n_i(reset_n), .dma_if(if2));

  bsg_cache_dma_mem_model #(
    .addr_width_p(AW), .data_width_p(DW), .block_size_in_words_p(BS),
    .els_p(ELS), .read_latency_p(0)
  ) u_dut0 (.clk_i(clk), .reset_n_i(reset_n), .dma_if(if0));

  int            errors = 0;
  int            checks = 0;
  logic [DW-1:0] model [ELS];
  logic [DW-1:0] exp_q [$];
  int            vc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < int'(ELS); i++) model[i] = DW'(i);
  endtask

  function automatic int block_idx(input logic [31:0] addr);
    return int'((addr >> 2) % ELS) & ~(int'(BS) - 1);
  endfunction

  // Read one block. toggle drives ready 1,0,1,0... counted from the first fill beat.
  task automatic read_burst(input bit s, input logic [31:0] addr, input bit toggle,
                            input int lat, output int vcount);
    int t, idx, budget;
    idx = block_idx(addr);
    for (int k = 0; k < int'(BS); k++) exp_q.push_back(model[(idx + k) % int'(ELS)]);
    sel = s;
    tick();
    pkt   = {1'b0, addr};
    pkt_v = 1'b1;
    ready = 1'b1;
    @(negedge clk);
    check("rd_pkt_yumi", 32'(yumi), 32'd1);
    t = cyc;
    tick();
    pkt_v  = 1'b0;
    vcount = 0;
    budget = 0;
    while (exp_q.size() > 0 && budget < 40) begin
      ready = toggle ? (vcount % 2 == 0) : 1'b1;
      @(negedge clk);
      if (dv) begin
        if (vcount == 0) check("first_beat_latency", 32'(cyc - t), 32'(1 + lat));
        vcount++;
        if (ready) check("fill_data", dout, exp_q.pop_front());
        else       check("fill_data_held", dout, exp_q[0]);
      end
      budget++;
      tick();
    end
    check("fill_timeout_left", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    ready = 1'b0;
    @(negedge clk);
    check("rd_busy_after", 32'(busy), 32'd0);
  endtask

  // Write one block of d0, d0+1, ... to u_dut2. If abort_at < BS, reset is pulsed during that beat.
  task automatic write_burst(input logic [31:0] addr, input logic [31:0] d0, input int abort_at);
    int idx;
    idx = block_idx(addr);
    sel = 1'b0;
    tick();
    pkt   = {1'b1, addr};
    pkt_v = 1'b1;
    @(negedge clk);
    check("wr_pkt_yumi", 32'(yumi), 32'd1);
    tick();
    pkt_v = 1'b0;
    for (int k = 0; k < int'(BS); k++) begin
      dat   = d0 + 32'(k);
      dat_v = 1'b1;
      if (k == abort_at) begin
        #2 reset_n = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_data_yumi", 32'(dyumi), 32'd0);
        check("rst_data_v", 32'(dv), 32'd0);
        check("rst_data_o", dout, 32'd0);
        dat_v = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        return;
      end
      @(negedge clk);
      check("wr_data_yumi", 32'(dyumi), 32'd1);
      model[(idx + k) % int'(ELS)] = d0 + 32'(k);
      tick();
    end
    dat_v = 1'b0;
    @(negedge clk);
    check("wr_busy_after", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    model_reset();
    reset_n = 1'b0;
    sel     = 1'b0;
    pkt     = '0;
    pkt_v   = 1'b1;
    ready   = 1'b1;
    dat     = 32'hDEAD;
    dat_v   = 1'b1;
    #12;
    check("reset_pkt_yumi", 32'(yumi), 32'd0);
    check("reset_data_yumi", 32'(dyumi), 32'd0);
    check("reset_data_v", 32'(dv), 32'd0);
    check("reset_data_o", dout, 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    pkt_v = 1'b0;
    dat_v = 1'b0;
    ready = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;

    // Read 0x40 -> words 16..19, first beat three cycles after the accept
    read_burst(1'b0, 32'h40, 1'b0, 2, vc);
    check("t1_vcount", 32'(vc), 32'd4);

    // Evict data offered while idle must not be consumed
    tick();
    dat_v = 1'b1;
    @(negedge clk);
    check("idle_evict_ignored", 32'(dyumi), 32'd0);
    tick();
    dat_v = 1'b0;

    // Zero-latency instance, aligned and misaligned address into the same block
    read_burst(1'b1, 32'h10, 1'b0, 0, vc);
    read_burst(1'b1, 32'h14, 1'b0, 0, vc);

    // Write-then-read returns the new data; neighbouring block untouched
    write_burst(32'h40, 32'hA0, int'(BS));
    read_burst(1'b0, 32'h40, 1'b0, 2, vc);
    read_burst(1'b0, 32'h50, 1'b0, 2, vc);

    // Backpressure: ready toggling stretches the burst to 7 valid cycles
    read_burst(1'b0, 32'h00, 1'b1, 2, vc);
    check("t3_vcount", 32'(vc), 32'd7);

    // Address wrap and the top block
    read_burst(1'b0, 32'h200, 1'b0, 2, vc);
    read_burst(1'b0, 32'h1F0, 1'b0, 2, vc);

    // Reset during beat 2 of a write discards it
    write_burst(32'h40, 32'hB0, 2);
    read_burst(1'b0, 32'h40, 1'b0, 2, vc);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
